// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bus of the scoreboarded register file.
// Master drives read addresses, the write port and scoreboard sets; slave is the register file.
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREAD = 2,
    parameter int AW    = 5
);
    logic [NREAD*AW-1:0]   rd_addr;
    logic [NREAD*XLEN-1:0] rd_data;
    logic [NREAD-1:0]      rd_busy;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic                  sb_set;
    logic [AW-1:0]         sb_addr;
    logic                  any_busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr,
        input  rd_data, rd_busy, any_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr,
        output rd_data, rd_busy, any_busy
    );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with NREAD registered read ports, write-first bypass,
// optional hardwired-zero register 0 and a per-register pending-write scoreboard.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);

    logic [XLEN-1:0]       regs_q [NREGS];
    logic [NREGS-1:0]      pend_q;
    logic [NREGS-1:0]      pend_d;
    logic [NREAD*XLEN-1:0] rd_data_q;
    logic [NREAD*XLEN-1:0] rd_data_d;
    logic [NREAD-1:0]      rd_busy_q;
    logic [NREAD-1:0]      rd_busy_d;
    logic                  wr_ok;
    logic                  sb_ok;
    logic                  any_busy;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return int'(a) < NREGS;
    endfunction

    // Register 0 is excluded from storage and scoreboard when hardwired to zero.
    function automatic logic writable(input logic [AW-1:0] a);
        return addr_ok(a) && !((ZERO_REG != 0) && (a == AW'(0)));
    endfunction

    assign wr_ok = bus.wr_en  && writable(bus.wr_addr);
    assign sb_ok = bus.sb_set && writable(bus.sb_addr);

    // Next pending state: a set beats a same-address clear since a newer writer is in flight.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < NREGS; i++) begin
            pend_d[i] = (sb_ok && (bus.sb_addr == AW'(i))) ? 1'b1 :
                        (wr_ok && (bus.wr_addr == AW'(i))) ? 1'b0 : pend_q[i];
        end
    end

    // Read-port next values, bypassing the same-cycle write and scoreboard update.
    always_comb begin
        logic [AW-1:0] a;
        a         = AW'(0);
        rd_data_d = (NREAD*XLEN)'(0);
        rd_busy_d = NREAD'(0);
        for (int k = 0; k < NREAD; k++) begin
            a = bus.rd_addr[k*AW +: AW];
            rd_data_d[k*XLEN +: XLEN] = !writable(a) ? XLEN'(0) :
                                        (wr_ok && (bus.wr_addr == a)) ? bus.wr_data : regs_q[a];
            rd_busy_d[k] = addr_ok(a) ? pend_d[a] : 1'b0;
        end
    end

    // Stall hint from the committed pending bits only.
    always_comb begin
        logic [AW-1:0] a;
        a        = AW'(0);
        any_busy = 1'b0;
        for (int k = 0; k < NREAD; k++) begin
            a        = bus.rd_addr[k*AW +: AW];
            any_busy = any_busy | (addr_ok(a) & pend_q[a]);
        end
    end

    // Storage array update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= XLEN'(0);
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_ok && (bus.wr_addr == AW'(i))) begin
                    regs_q[i] <= bus.wr_data;
                end
            end
        end
    end

    // Scoreboard and registered read outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q    <= NREGS'(0);
            rd_data_q <= (NREAD*XLEN)'(0);
            rd_busy_q <= NREAD'(0);
        end else begin
            pend_q    <= pend_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_busy  = rd_busy_q;
    assign bus.any_busy = any_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: expected read results are queued when stimulus is applied
// and compared when the registered outputs appear one edge later.
module tb_regfile_sb;
    localparam int XLEN  = 32;
    localparam int NREGS = 24;
    localparam int NREAD = 2;
    localparam int AW    = $clog2(NREGS);

    typedef struct packed {
        logic [NREAD*XLEN-1:0] data;
        logic [NREAD-1:0]      busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    logic [XLEN-1:0] m_regs [32];
    logic            m_pend [32];

    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(XLEN), .NREAD(NREAD), .AW(AW)) bus ();

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int r0, input int r1, input logic we, input int wa,
                         input logic [XLEN-1:0] wd, input logic ss, input int sa);
        bus.rd_addr = {AW'(r1), AW'(r0)};
        bus.wr_en   = we;
        bus.wr_addr = AW'(wa);
        bus.wr_data = wd;
        bus.sb_set  = ss;
        bus.sb_addr = AW'(sa);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_pend[i] = 1'b0;
        end
    endtask

    // One clock of traffic: check any_busy on current state, queue the post-edge expectation, compare it.
    task automatic cycle(input string tag);
        exp_t e;
        logic eb;
        int   a;
        int   wa;
        int   sa;
        @(negedge clk);
        eb = 1'b0;
        for (int k = 0; k < NREAD; k++) begin
            a = int'(bus.rd_addr[k*AW +: AW]);
            if (a < NREGS && m_pend[a]) eb = 1'b1;
        end
        chk({tag, ".any_busy"}, 64'(bus.any_busy), 64'(eb));
        wa = int'(bus.wr_addr);
        sa = int'(bus.sb_addr);
        if (bus.wr_en && wa < NREGS && wa != 0) begin
            m_regs[wa] = bus.wr_data;
            m_pend[wa] = 1'b0;
        end
        if (bus.sb_set && sa < NREGS && sa != 0) m_pend[sa] = 1'b1;
        for (int k = 0; k < NREAD; k++) begin
            a = int'(bus.rd_addr[k*AW +: AW]);
            e.data[k*XLEN +: XLEN] = (a < NREGS && a != 0) ? m_regs[a] : 32'h0;
            e.busy[k]              = (a < NREGS) ? m_pend[a] : 1'b0;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".rd_data"}, 64'(bus.rd_data), 64'(e.data));
        chk({tag, ".rd_busy"}, 64'(bus.rd_busy), 64'(e.busy));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        drive(0, 0, 1'b0, 0, 32'h0, 1'b0, 0);
        repeat (2) @(negedge clk);
        chk("reset.rd_data", 64'(bus.rd_data), 64'h0);
        chk("reset.rd_busy", 64'(bus.rd_busy), 64'h0);
        rst = 1'b0;

        for (int a = 0; a < 32; a++) begin
            drive(a, 31 - a, 1'b0, 0, 32'h0, 1'b0, 0);
            cycle("reset_scan");
        end

        drive(0, 0, 1'b1, 5, 32'hDEADBEEF, 1'b0, 0);
        cycle("wr5");
        drive(5, 0, 1'b0, 0, 32'h0, 1'b0, 0);
        cycle("rd5");
        chk("rd5.const", 64'(bus.rd_data[XLEN-1:0]), 64'hDEADBEEF);

        drive(0, 0, 1'b1, 0, 32'h1234, 1'b1, 0);
        cycle("wr0");
        drive(0, 0, 1'b0, 0, 32'h0, 1'b0, 0);
        cycle("rd0");

        drive(0, 0, 1'b1, 7, 32'h1, 1'b0, 0);
        cycle("wr7_old");
        drive(7, 7, 1'b1, 7, 32'hA5A5A5A5, 1'b0, 0);
        cycle("bypass7");
        chk("bypass7.const", 64'(bus.rd_data), {32'hA5A5A5A5, 32'hA5A5A5A5});

        drive(0, 3, 1'b0, 0, 32'h0, 1'b1, 3);
        cycle("sb3_set");
        drive(0, 3, 1'b0, 0, 32'h0, 1'b0, 0);
        cycle("sb3_hold");
        drive(0, 3, 1'b1, 3, 32'h42, 1'b0, 0);
        cycle("sb3_clear");
        chk("sb3_clear.const", 64'(bus.rd_busy), 64'h0);
        drive(3, 3, 1'b1, 3, 32'h55, 1'b1, 3);
        cycle("sb3_setwins");
        chk("sb3_setwins.const", 64'(bus.rd_busy), 64'h3);
        drive(3, 10, 1'b1, 3, 32'h66, 1'b1, 10);
        cycle("sb_diff");
        drive(3, 10, 1'b0, 0, 32'h0, 1'b0, 0);
        cycle("sb_diff_hold");

        drive(28, 23, 1'b1, 28, 32'h12345678, 1'b1, 28);
        cycle("oor_wr");
        drive(28, 24, 1'b0, 0, 32'h0, 1'b0, 0);
        cycle("oor_rd");

        for (int i = 0; i < 300; i++) begin
            drive(int'($urandom_range(31)), int'($urandom_range(31)), 1'($urandom_range(1)),
                  int'($urandom_range(31)), $urandom, 1'($urandom_range(1)), int'($urandom_range(31)));
            cycle("rand");
        end

        for (int r = 1; r <= 4; r++) begin
            drive(0, 0, 1'b1, r, 32'h100 + 32'(r), 1'b0, 0);
            cycle("pre_rst_wr");
        end
        drive(1, 9, 1'b0, 0, 32'h0, 1'b1, 9);
        cycle("pre_rst_sb");
        drive(1, 9, 1'b0, 0, 32'h0, 1'b0, 0);
        cycle("pre_rst_rd");
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.rd_data", 64'(bus.rd_data), 64'h0);
        chk("midrst.rd_busy", 64'(bus.rd_busy), 64'h0);
        chk("midrst.any_busy", 64'(bus.any_busy), 64'h0);
        model_clear();
        #1;
        rst = 1'b0;
        for (int r = 1; r <= 4; r++) begin
            drive(r, 9, 1'b0, 0, 32'h0, 1'b0, 0);
            cycle("post_rst");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
